core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Shares the single external data-memory bus between core0 and core1.
- Each core's memwb data-memory port (addr/data/req/we/sel/long/addr_high, ack, exception) lands on one side; one downstream master port goes toward the wishbone/memory controller.
- Round-robin, one transaction at a time, grant held until ack/exception/abort.
- A watchdog converts a hung transaction into a memory exception to the owning core.

Parameters:
- RW, 16, data/address word width (matches `RW).
- SEL_W, 2, byte-select width (matches `ADDR_BYTES).
- TIMEOUT, 255, cycles without ack before forced exception; 0 disables the watchdog.
- TO_W, 8, watchdog counter width; must satisfy TIMEOUT < 2**TO_W.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- c0_mem_req, c0_mem_we, c0_mem_long  in  1 each  core0 request/write/long-mode
- c0_mem_addr, c0_mem_data  in  RW each  core0 address, write data
- c0_mem_sel  in  SEL_W  core0 byte select
- c0_mem_addr_high  in  8  core0 long-address high byte
- c0_mem_ack, c0_mem_exception  out  1 each  completion / fault to core0
- c0_mem_rdata  out  RW  read data to core0
- c1_*  same set as c0_*  core1
- m_mem_req, m_mem_we, m_mem_long  out  1 each  downstream request fields
- m_mem_addr, m_mem_data  out  RW each
- m_mem_sel  out  SEL_W
- m_mem_addr_high  out  8
- m_mem_ack, m_mem_exception  in  1 each  downstream completion / fault
- m_mem_rdata  in  RW  downstream read data
- o_grant  out  1  current owner (0=core0, 1=core1), valid when o_busy
- o_busy  out  1  transaction in flight

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset state:
  - state=IDLE, grant=0, last=1 (core0 wins first), wd_cnt=0.
  - All outputs 0: m_mem_req=0, o_busy=0, c*_ack=0, c*_exception=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both request: grant ~last.
  - On a grant: register grant, go to BUSY, clear wd_cnt.
  - Arbitration cost: one cycle. A request sampled in cycle N gives m_mem_req=1 in cycle N+1.
- BUSY:
  - m_mem_* fields are combinationally muxed from the granted core's live inputs.
  - m_mem_req = granted core's req.
  - The non-granted core sees ack=0, exception=0 and simply waits; its req stays pending.
- BUSY exits, in priority order:
  1. m_mem_ack=1: granted core's ack=1 combinationally, same cycle; rdata = m_mem_rdata. last:=grant, go to IDLE.
  2. m_mem_exception=1: granted core's exception=1 same cycle, no ack. last:=grant, go to IDLE.
  3. Granted core drops req (abort, e.g. pipeline flush): m_mem_req=0 that cycle, go to IDLE, last:=grant. A late downstream ack in IDLE is discarded and routed to no core.
  4. TIMEOUT!=0 and wd_cnt==TIMEOUT:
     - Granted core gets exception=1 for one cycle, m_mem_req forced to 0, go to IDLE, last:=grant.
     - wd_cnt increments each BUSY cycle without ack and saturates; it never wraps.
- Simultaneous events:
  - Ack together with timeout: ack wins.
  - Ack together with the core dropping req: ack is still delivered.
- The FSM returns to IDLE after every exit, so back-to-back requests from the same core cost one idle cycle. If both cores request, the other core is served next (strict alternation).
- c*_rdata: driven with m_mem_rdata only to the granted core while BUSY, otherwise 0.
- Reset asserted mid-transaction: FSM returns to IDLE at once, m_mem_req drops asynchronously, and no ack/exception is produced.

Decomposition:
- Shared package/config: RW, ADDR_BYTES (already in config.v); arbiter state encodings IDLE=1'b0, BUSY=1'b1 as `define constants.
- One natural sub-module: mem_arb_watchdog.
  - Ports: clk, rst, clear, run, expired.
  - Function: saturating TO_W-bit counter with TIMEOUT compare.
- Everything else is flat in core_mem_arbiter.

Test Plan:
- Idle/single request:
  - Stimulus: only c0_mem_req=1, addr=0x1234, we=1, data=0xBEEF, sel=2'b11.
  - Required: m_mem_req=1 with those fields the next cycle. Downstream ack two cycles later gives c0_mem_ack=1 in the same cycle, c1_mem_ack=0, o_busy=0 the cycle after.
- Contention round-robin:
  - Stimulus: c0 and c1 request together from reset, each acked after 1 cycle, both kept asserted.
  - Required: grant order 0,1,0,1. c1 read returns m_mem_rdata=0x00A5 on c1_mem_rdata only.
- Downstream exception:
  - Stimulus: grant core1, assert m_mem_exception=1.
  - Required: c1_mem_exception=1 that cycle, c1_mem_ack=0, next grant goes to core0 if it is requesting.
- Watchdog:
  - Stimulus: TIMEOUT=4, grant core0, never ack.
  - Required: c0_mem_exception pulses exactly once, 4 cycles after entering BUSY, with m_mem_req=0 that cycle. Repeat with ack arriving on the expiry cycle: ack delivered, no exception.
- Abort:
  - Stimulus: core0 drops req 2 cycles into BUSY, then a stray m_mem_ack arrives.
  - Required: FSM in IDLE, c0/c1 ack stay 0, a pending c1 request is granted next.
- Reset mid-operation:
  - Stimulus: assert i_rst asynchronously during BUSY.
  - Required: m_mem_req=0 and o_busy=0 immediately, without waiting for a clock edge. After release, core0 wins first contention.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and helpers for the two-core data-memory arbiter.
package core_mem_arbiter_pkg;

    // Arbiter FSM encoding: IDLE waits for a request, BUSY owns the bus.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Round-robin pick: a lone requester wins, contention goes to the core
    // that was not served last.
    function automatic logic pick_core(input logic req0, input logic req1, input logic last);
        logic winner;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
        return winner;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_watchdog.sv
// Watchdog for the arbiter: a saturating cycle counter that flags when a
// granted transaction has waited TIMEOUT cycles without completing.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [TO_W-1:0] TO_VAL  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    logic [TO_W-1:0] r_cnt;

    // Count waiting cycles; clear on a new grant, hold at all-ones so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A zero TIMEOUT disables expiry entirely.
    assign expired = (TIMEOUT != 0) && (r_cnt == TO_VAL);

endmodule

// File: rtl/core_mem_arbiter.sv
// Two-core data-memory arbiter: round-robin, one transaction at a time, grant
// held until downstream ack/exception, core abort or watchdog expiry.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int RW      = 16,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    // core0 port
    input  logic             c0_mem_req,
    input  logic             c0_mem_we,
    input  logic             c0_mem_long,
    input  logic [RW-1:0]    c0_mem_addr,
    input  logic [RW-1:0]    c0_mem_data,
    input  logic [SEL_W-1:0] c0_mem_sel,
    input  logic [7:0]       c0_mem_addr_high,
    output logic             c0_mem_ack,
    output logic             c0_mem_exception,
    output logic [RW-1:0]    c0_mem_rdata,
    // core1 port
    input  logic             c1_mem_req,
    input  logic             c1_mem_we,
    input  logic             c1_mem_long,
    input  logic [RW-1:0]    c1_mem_addr,
    input  logic [RW-1:0]    c1_mem_data,
    input  logic [SEL_W-1:0] c1_mem_sel,
    input  logic [7:0]       c1_mem_addr_high,
    output logic             c1_mem_ack,
    output logic             c1_mem_exception,
    output logic [RW-1:0]    c1_mem_rdata,
    // downstream master port
    output logic             m_mem_req,
    output logic             m_mem_we,
    output logic             m_mem_long,
    output logic [RW-1:0]    m_mem_addr,
    output logic [RW-1:0]    m_mem_data,
    output logic [SEL_W-1:0] m_mem_sel,
    output logic [7:0]       m_mem_addr_high,
    input  logic             m_mem_ack,
    input  logic             m_mem_exception,
    input  logic [RW-1:0]    m_mem_rdata,
    // status
    output logic             o_grant,
    output logic             o_busy
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_grant;
    logic       w_grant_next;
    logic       r_last;
    logic       w_last_next;

    logic       w_busy;
    logic       w_sel_req;
    logic       w_wd_clear;
    logic       w_wd_run;
    logic       w_wd_expired;
    logic       w_to_fire;

    logic [1:0]    w_core_ack;
    logic [1:0]    w_core_exc;
    logic [RW-1:0] w_core_rdata [2];

    assign w_busy    = (r_state == ST_BUSY);
    assign w_sel_req = r_grant ? c1_mem_req : c0_mem_req;

    // Watchdog only fires when nothing of higher priority ends the transaction.
    assign w_to_fire = w_busy && w_wd_expired && !m_mem_ack && !m_mem_exception && w_sel_req;
    assign w_wd_run  = w_busy && !m_mem_ack;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (w_wd_clear),
        .run     (w_wd_run),
        .expired (w_wd_expired)
    );

    // FSM state, owner and round-robin history registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
        end
    end

    // Next-state: arbitrate in IDLE, leave BUSY on any completion/abort/expiry.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_wd_clear   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (c0_mem_req || c1_mem_req) begin
                    w_grant_next = pick_core(c0_mem_req, c1_mem_req, r_last);
                    w_state_next = ST_BUSY;
                    w_wd_clear   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (m_mem_ack || m_mem_exception || !w_sel_req || w_to_fire) begin
                    w_state_next = ST_IDLE;
                    w_last_next  = r_grant;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Downstream request fields follow the owner's live inputs while BUSY.
    always_comb begin
        m_mem_req       = 1'b0;
        m_mem_we        = 1'b0;
        m_mem_long      = 1'b0;
        m_mem_addr      = '0;
        m_mem_data      = '0;
        m_mem_sel       = '0;
        m_mem_addr_high = '0;
        if (w_busy) begin
            m_mem_req       = w_sel_req && !w_to_fire;
            m_mem_we        = r_grant ? c1_mem_we        : c0_mem_we;
            m_mem_long      = r_grant ? c1_mem_long      : c0_mem_long;
            m_mem_addr      = r_grant ? c1_mem_addr      : c0_mem_addr;
            m_mem_data      = r_grant ? c1_mem_data      : c0_mem_data;
            m_mem_sel       = r_grant ? c1_mem_sel       : c0_mem_sel;
            m_mem_addr_high = r_grant ? c1_mem_addr_high : c0_mem_addr_high;
        end
    end

    // Per-core responses: only the owner sees ack/exception/rdata; a late ack in IDLE goes nowhere.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_core_rsp
            logic w_owner;
            assign w_owner          = w_busy && (r_grant == 1'(gi));
            assign w_core_ack[gi]   = w_owner && m_mem_ack;
            assign w_core_exc[gi]   = w_owner && ((m_mem_exception && !m_mem_ack) || w_to_fire);
            assign w_core_rdata[gi] = w_owner ? m_mem_rdata : '0;
        end
    endgenerate

    assign c0_mem_ack       = w_core_ack[0];
    assign c0_mem_exception = w_core_exc[0];
    assign c0_mem_rdata     = w_core_rdata[0];
    assign c1_mem_ack       = w_core_ack[1];
    assign c1_mem_exception = w_core_exc[1];
    assign c1_mem_rdata     = w_core_rdata[1];

    assign o_grant = r_grant;
    assign o_busy  = w_busy;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model of the arbiter.
module tb_core_mem_arbiter;

    localparam int RW      = 16;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;

    logic             req  [2];
    logic             we   [2];
    logic             lng  [2];
    logic [RW-1:0]    addr [2];
    logic [RW-1:0]    data [2];
    logic [SEL_W-1:0] sel  [2];
    logic [7:0]       ah   [2];

    logic             c0_ack, c0_exc, c1_ack, c1_exc;
    logic [RW-1:0]    c0_rdata, c1_rdata;

    logic             m_req, m_we, m_long;
    logic [RW-1:0]    m_addr, m_data;
    logic [SEL_W-1:0] m_sel;
    logic [7:0]       m_ah;
    logic             m_ack, m_exc;
    logic [RW-1:0]    m_rdata;
    logic             o_grant, o_busy;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: is a transaction open, who owns it, how many
    // BUSY cycles it has waited, and who was served last.
    bit md_busy;
    bit md_owner;
    bit md_last;
    int md_age;
    int txn_no = 0;

    always #5 clk = ~clk;

    core_mem_arbiter #(
        .RW(RW), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .TO_W(8)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .c0_mem_req(req[0]), .c0_mem_we(we[0]), .c0_mem_long(lng[0]),
        .c0_mem_addr(addr[0]), .c0_mem_data(data[0]), .c0_mem_sel(sel[0]),
        .c0_mem_addr_high(ah[0]), .c0_mem_ack(c0_ack), .c0_mem_exception(c0_exc),
        .c0_mem_rdata(c0_rdata),
        .c1_mem_req(req[1]), .c1_mem_we(we[1]), .c1_mem_long(lng[1]),
        .c1_mem_addr(addr[1]), .c1_mem_data(data[1]), .c1_mem_sel(sel[1]),
        .c1_mem_addr_high(ah[1]), .c1_mem_ack(c1_ack), .c1_mem_exception(c1_exc),
        .c1_mem_rdata(c1_rdata),
        .m_mem_req(m_req), .m_mem_we(m_we), .m_mem_long(m_long),
        .m_mem_addr(m_addr), .m_mem_data(m_data), .m_mem_sel(m_sel),
        .m_mem_addr_high(m_ah), .m_mem_ack(m_ack), .m_mem_exception(m_exc),
        .m_mem_rdata(m_rdata),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        md_busy  = 1'b0;
        md_owner = 1'b0;
        md_last  = 1'b1;
        md_age   = 0;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; lng[i] = 1'b0;
            addr[i] = '0; data[i] = '0; sel[i] = '0; ah[i] = '0;
        end
        m_ack = 1'b0; m_exc = 1'b0; m_rdata = '0;
    endtask

    // One cycle: compare all outputs with the model, then advance the model
    // across the rising edge. Called just after a falling edge.
    task automatic step();
        bit          o;
        bit          to_fire;
        logic [43:0] exp_f;
        logic [43:0] got_f;
        #1;
        o       = md_owner;
        to_fire = md_busy && !m_ack && !m_exc && req[o] && (md_age == TIMEOUT);
        exp_f   = md_busy ? {we[o], lng[o], sel[o], ah[o], addr[o], data[o]} : 44'h0;
        got_f   = {m_we, m_long, m_sel, m_ah, m_addr, m_data};
        check("busy",   64'(o_busy), 64'(md_busy));
        check("m_req",  64'(m_req),  64'(md_busy && req[o] && !to_fire));
        check("fields", 64'(got_f),  64'(exp_f));
        if (md_busy) check("grant", 64'(o_grant), 64'(o));
        check("c0_ack", 64'(c0_ack), 64'(md_busy && !o && m_ack));
        check("c1_ack", 64'(c1_ack), 64'(md_busy &&  o && m_ack));
        check("c0_exc", 64'(c0_exc), 64'(md_busy && !o && ((m_exc && !m_ack) || to_fire)));
        check("c1_exc", 64'(c1_exc), 64'(md_busy &&  o && ((m_exc && !m_ack) || to_fire)));
        check("c0_rdata", 64'(c0_rdata), 64'((md_busy && !o) ? m_rdata : '0));
        check("c1_rdata", 64'(c1_rdata), 64'((md_busy &&  o) ? m_rdata : '0));
        @(posedge clk);
        if (!md_busy) begin
            if (req[0] || req[1]) begin
                md_owner = (req[0] && req[1]) ? !md_last : req[1];
                md_busy  = 1'b1;
                md_age   = 0;
            end
        end else if (m_ack || m_exc || !req[o] || to_fire) begin
            txn_no++;
            $display("txn %0d core%0d end=%s waited=%0d", txn_no, o,
                     m_ack ? "ack" : (m_exc ? "exception" : (!req[o] ? "abort" : "timeout")), md_age);
            md_last = o;
            md_busy = 1'b0;
        end else begin
            md_age++;
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_busy",  64'(o_busy), 64'(0));
        check("rst_m_req", 64'(m_req),  64'(0));
        check("rst_acks",  64'({c0_ack, c1_ack, c0_exc, c1_exc}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Contention from reset: strict alternation starting with core0.
        req[0] = 1'b1; req[1] = 1'b1; m_rdata = 16'h00A5;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            check("rr_order", 64'(o_grant), 64'(k % 2));
            m_ack = 1'b1;
            #1;
            if (k % 2 == 1) begin
                check("rr_c1_rdata", 64'(c1_rdata), 64'(16'h00A5));
                check("rr_c0_rdata", 64'(c0_rdata), 64'(0));
            end
            step();
            m_ack = 1'b0;
        end
        clear_inputs();
        step();

        // Single request from core0, acked two cycles after it reaches the bus.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h1234; data[0] = 16'hBEEF; sel[0] = 2'b11;
        step();
        #1;
        check("t1_m_req",  64'(m_req),  64'(1));
        check("t1_addr",   64'(m_addr), 64'(16'h1234));
        check("t1_data",   64'(m_data), 64'(16'hBEEF));
        check("t1_we_sel", 64'({m_we, m_sel}), 64'(3'b111));
        step();
        step();
        m_ack = 1'b1;
        #1;
        check("t1_c0_ack", 64'(c0_ack), 64'(1));
        check("t1_c1_ack", 64'(c1_ack), 64'(0));
        step();
        clear_inputs();
        #1;
        check("t1_idle", 64'(o_busy), 64'(0));
        step();

        // Downstream exception on core1, core0 served next.
        req[1] = 1'b1;
        step();
        step();
        req[0] = 1'b1; m_exc = 1'b1;
        #1;
        check("ex_c1_exc", 64'(c1_exc), 64'(1));
        check("ex_c1_ack", 64'(c1_ack), 64'(0));
        step();
        m_exc = 1'b0;
        step();
        #1;
        check("ex_next", 64'(o_grant), 64'(0));
        m_ack = 1'b1;
        step();
        clear_inputs();
        step();

        // Watchdog expiry with no ack, then ack landing on the expiry cycle.
        for (int rep = 0; rep < 2; rep++) begin
            req[0] = 1'b1;
            step();
            for (int a = 0; a < TIMEOUT; a++) step();
            m_ack = (rep == 1);
            #1;
            check("wd_exc",   64'(c0_exc), 64'(rep == 0));
            check("wd_ack",   64'(c0_ack), 64'(rep == 1));
            check("wd_m_req", 64'(m_req),  64'(rep == 1));
            step();
            clear_inputs();
            #1;
            check("wd_once", 64'(c0_exc), 64'(0));
            step();
        end

        // Abort by core0 with core1 pending, stray ack afterwards.
        req[0] = 1'b1;
        step();
        req[1] = 1'b1;
        step();
        step();
        req[0] = 1'b0;
        step();
        m_ack = 1'b1;
        #1;
        check("ab_stray", 64'({c0_ack, c1_ack}), 64'(0));
        step();
        m_ack = 1'b0;
        #1;
        check("ab_next", 64'(o_grant), 64'(1));
        m_ack = 1'b1;
        step();
        clear_inputs();
        step();

        // Asynchronous reset during BUSY.
        req[0] = 1'b1; req[1] = 1'b1;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_m_req", 64'(m_req),  64'(0));
        check("arst_busy",  64'(o_busy), 64'(0));
        check("arst_rsp",   64'({c0_ack, c1_ack, c0_exc, c1_exc}), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        #1;
        check("arst_first", 64'(o_grant), 64'(0));
        clear_inputs();
        step();
        step();

        // Random traffic.
        for (int blk = 0; blk < 16; blk++) begin
            int ack_pct;
            ack_pct = (blk % 3 == 0) ? 0 : 30;
            for (int c = 0; c < 50; c++) begin
                for (int i = 0; i < 2; i++) begin
                    req[i]  = req[i] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
                    we[i]   = 1'($urandom);
                    lng[i]  = 1'($urandom);
                    addr[i] = 16'($urandom);
                    data[i] = 16'($urandom);
                    sel[i]  = 2'($urandom);
                    ah[i]   = 8'($urandom);
                end
                m_ack   = ($urandom_range(0, 99) < ack_pct);
                m_exc   = ($urandom_range(0, 99) < 5);
                m_rdata = 16'($urandom);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
